// File: rtl/axi_result_packer_pkg.sv
// Shared types and constants for the GCD result packer and its unpacker counterpart.
// Defines the AXI burst shape and the burst-sequencing state enum.
package axi_result_packer_pkg;

    localparam int GCD_RES_W = 1284;
    localparam int AXI_DW    = 64;
    localparam int BEATS     = 21;
    localparam int SHIFT_W   = BEATS * AXI_DW;
    localparam int PAD_W     = SHIFT_W - GCD_RES_W;

    localparam logic [7:0] AXI_LEN        = 8'(BEATS - 1);
    localparam logic [2:0] AXI_SIZE_8B    = 3'b011;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [3:0] AXI_CACHE_BUF  = 4'b0011;
    localparam logic [1:0] RESP_OKAY      = 2'b00;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_AW_A  = 3'd1,
        ST_W_A   = 3'd2,
        ST_RSP_A = 3'd3,
        ST_AW_B  = 3'd4,
        ST_W_B   = 3'd5,
        ST_RSP_B = 3'd6
    } pkr_state_e;

    function automatic logic [SHIFT_W-1:0] pad_result(input logic [GCD_RES_W-1:0] res);
        return {{PAD_W{1'b0}}, res};
    endfunction

endpackage

// File: rtl/axi_result_packer_serializer.sv
// Holds the zero-padded A/B snapshots and slices the selected one into 64-bit beats.
// The shared beat counter wraps after the last beat so burst B starts at beat 0.
module gcd_beat_serializer
    import axi_result_packer_pkg::*;
(
    input  logic                 CLK,
    input  logic                 RESETn,
    input  logic                 i_load,
    input  logic [GCD_RES_W-1:0] i_res_a,
    input  logic [GCD_RES_W-1:0] i_res_b,
    input  logic                 i_sel_b,
    input  logic                 i_beat_ack,
    output logic [AXI_DW-1:0]    o_data,
    output logic                 o_last
);

    localparam logic [4:0] LAST_BEAT = 5'(BEATS - 1);

    logic [SHIFT_W-1:0] r_sh_a;
    logic [SHIFT_W-1:0] r_sh_b;
    logic [4:0]         r_cnt;

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            r_sh_a <= '0;
            r_sh_b <= '0;
            r_cnt  <= '0;
        end else if (i_load) begin
            r_sh_a <= pad_result(i_res_a);
            r_sh_b <= pad_result(i_res_b);
            r_cnt  <= '0;
        end else if (i_beat_ack) begin
            if (i_sel_b) begin
                r_sh_b <= r_sh_b >> AXI_DW;
            end else begin
                r_sh_a <= r_sh_a >> AXI_DW;
            end
            r_cnt <= (r_cnt == LAST_BEAT) ? 5'd0 : r_cnt + 5'd1;
        end
    end

    assign o_data = i_sel_b ? r_sh_b[AXI_DW-1:0] : r_sh_a[AXI_DW-1:0];
    assign o_last = (r_cnt == LAST_BEAT);

endmodule

// File: rtl/axi_result_packer.sv
// AXI4 write initiator: on DONE, snapshots RESULT_A/RESULT_B and writes each as a 21-beat burst.
// Optional macro AXI_RESULT_PACKER_BRESP_CHECK_EN enables the sticky BRESP/BID error flag.
//
// state    | meaning
// ST_IDLE  | waiting for DONE; capture snapshot and base address
// ST_AW_A  | address of burst A presented
// ST_W_A   | streaming 21 beats of RESULT_A
// ST_RSP_A | waiting for write response of burst A
// ST_AW_B  | address of burst B (base + B_OFFSET) presented
// ST_W_B   | streaming 21 beats of RESULT_B
// ST_RSP_B | waiting for write response of burst B
module axi_result_packer
    import axi_result_packer_pkg::*;
#(
    parameter logic [3:0]  AXI_ID   = 4'h0,
    parameter logic [31:0] B_OFFSET = 32'h100
) (
    input  logic                 CLK,
    input  logic                 RESETn,
    input  logic                 DONE,
    input  logic [31:0]          BASE_ADDR,
    input  logic [GCD_RES_W-1:0] RESULT_A,
    input  logic [GCD_RES_W-1:0] RESULT_B,
    output logic                 BUSY,
    output logic                 COMPLETE,
    output logic                 ERR,
    output logic [3:0]           AWID,
    output logic [31:0]          AWADDR,
    output logic [7:0]           AWLEN,
    output logic [2:0]           AWSIZE,
    output logic [1:0]           AWBURST,
    output logic                 AWLOCK,
    output logic [3:0]           AWCACHE,
    output logic [2:0]           AWPROT,
    output logic                 AWVALID,
    input  logic                 AWREADY,
    output logic [AXI_DW-1:0]    WDATA,
    output logic [7:0]           WSTRB,
    output logic                 WLAST,
    output logic                 WVALID,
    input  logic                 WREADY,
    input  logic [3:0]           BID,
    input  logic [1:0]           BRESP,
    input  logic                 BVALID,
    output logic                 BREADY
);

    pkr_state_e  r_state;
    pkr_state_e  w_next;
    logic [31:0] r_awaddr;
    logic        r_complete;
    logic        w_load;
    logic        w_sel_b;
    logic        w_last;
    logic        w_beat_ack;
    logic        w_b_hs;
    logic        w_awvalid;
    logic        w_wvalid;
    logic        w_bready;

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        w_load    = 1'b0;
        w_awvalid = 1'b0;
        w_wvalid  = 1'b0;
        w_bready  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (DONE) begin
                    w_load = 1'b1;
                    w_next = ST_AW_A;
                end
            end
            ST_AW_A: begin
                w_awvalid = 1'b1;
                if (AWREADY) w_next = ST_W_A;
            end
            ST_W_A: begin
                w_wvalid = 1'b1;
                if (WREADY && w_last) w_next = ST_RSP_A;
            end
            ST_RSP_A: begin
                w_bready = 1'b1;
                if (BVALID) w_next = ST_AW_B;
            end
            ST_AW_B: begin
                w_awvalid = 1'b1;
                if (AWREADY) w_next = ST_W_B;
            end
            ST_W_B: begin
                w_wvalid = 1'b1;
                if (WREADY && w_last) w_next = ST_RSP_B;
            end
            ST_RSP_B: begin
                w_bready = 1'b1;
                if (BVALID) w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    assign w_sel_b    = (r_state == ST_AW_B) || (r_state == ST_W_B) || (r_state == ST_RSP_B);
    assign w_beat_ack = w_wvalid && WREADY;
    assign w_b_hs     = w_bready && BVALID;

    // The B address is derived from the held A address when burst A is acknowledged.
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            r_awaddr   <= '0;
            r_complete <= 1'b0;
        end else begin
            r_complete <= w_b_hs && (r_state == ST_RSP_B);
            if (w_load) begin
                r_awaddr <= BASE_ADDR;
            end else if (w_b_hs && (r_state == ST_RSP_A)) begin
                r_awaddr <= r_awaddr + B_OFFSET;
            end
        end
    end

    gcd_beat_serializer u_ser (
        .CLK        (CLK),
        .RESETn     (RESETn),
        .i_load     (w_load),
        .i_res_a    (RESULT_A),
        .i_res_b    (RESULT_B),
        .i_sel_b    (w_sel_b),
        .i_beat_ack (w_beat_ack),
        .o_data     (WDATA),
        .o_last     (w_last)
    );

`ifdef AXI_RESULT_PACKER_BRESP_CHECK_EN
    logic r_err;

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            r_err <= 1'b0;
        end else if (w_load) begin
            r_err <= 1'b0;
        end else if (w_b_hs && ((BRESP != RESP_OKAY) || (BID != AXI_ID))) begin
            r_err <= 1'b1;
        end
    end

    assign ERR = r_err;
`else
    logic w_unused_bresp;
    assign w_unused_bresp = ^{BID, BRESP};
    assign ERR = 1'b0;
`endif

    assign BUSY     = (r_state != ST_IDLE);
    assign COMPLETE = r_complete;
    assign AWVALID  = w_awvalid;
    assign WVALID   = w_wvalid;
    assign BREADY   = w_bready;
    assign WLAST    = w_last;
    assign AWADDR   = r_awaddr;
    assign AWID     = AXI_ID;
    assign AWLEN    = AXI_LEN;
    assign AWSIZE   = AXI_SIZE_8B;
    assign AWBURST  = AXI_BURST_INCR;
    assign AWLOCK   = 1'b0;
    assign AWCACHE  = AXI_CACHE_BUF;
    assign AWPROT   = 3'b000;
    assign WSTRB    = 8'hFF;

endmodule

// File: tb/tb_axi_result_packer.sv
// Scoreboard bench for axi_result_packer: expected addresses/beats queued at DONE,
// a negedge monitor compares every presented AW/W against the queue heads.
module tb_axi_result_packer;
    import axi_result_packer_pkg::*;

    localparam logic [3:0]  TB_ID  = 4'h0;
    localparam logic [31:0] TB_OFF = 32'h100;

    logic                 CLK, RESETn, DONE;
    logic [31:0]          BASE_ADDR;
    logic [GCD_RES_W-1:0] RESULT_A, RESULT_B;
    logic                 BUSY, COMPLETE, ERR;
    logic [3:0]           AWID;
    logic [31:0]          AWADDR;
    logic [7:0]           AWLEN;
    logic [2:0]           AWSIZE;
    logic [1:0]           AWBURST;
    logic                 AWLOCK;
    logic [3:0]           AWCACHE;
    logic [2:0]           AWPROT;
    logic                 AWVALID, AWREADY;
    logic [63:0]          WDATA;
    logic [7:0]           WSTRB;
    logic                 WLAST, WVALID, WREADY;
    logic [3:0]           BID;
    logic [1:0]           BRESP;
    logic                 BVALID, BREADY;

    axi_result_packer #(.AXI_ID(TB_ID), .B_OFFSET(TB_OFF)) dut (
        .CLK(CLK), .RESETn(RESETn), .DONE(DONE), .BASE_ADDR(BASE_ADDR),
        .RESULT_A(RESULT_A), .RESULT_B(RESULT_B),
        .BUSY(BUSY), .COMPLETE(COMPLETE), .ERR(ERR),
        .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE),
        .AWBURST(AWBURST), .AWLOCK(AWLOCK), .AWCACHE(AWCACHE), .AWPROT(AWPROT),
        .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
        .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_errs   = 0;

    logic [31:0] qa[$];
    logic [64:0] qw[$];
    int  aw_hs_cnt = 0, w_hs_cnt = 0, aw_outstanding = 0, b_total = 0;
    int  aw_start = 0, w_start = 0, issue_cyc = 0, cyc = 0;
    int  err_target = -1;
    bit  hs_pending = 0;
    bit  rnd_mode = 0;
    bit  exp_err = 0;

    task automatic check_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_errs++;
        $display("FAIL %s", name);
    endtask

    // Reference: beat k of a result is the k-th 64-bit slice of the zero-padded 1344-bit value.
    function automatic logic [63:0] beat_of(input logic [GCD_RES_W-1:0] r, input int k);
        logic [1343:0] v;
        v = {60'b0, r};
        v = v >> (64 * k);
        return v[63:0];
    endfunction

    task automatic rand_res(output logic [GCD_RES_W-1:0] r);
        logic [1311:0] t;
        for (int i = 0; i < 41; i++) t[i*32 +: 32] = $urandom;
        r = t[GCD_RES_W-1:0];
    endtask

    task automatic push_expect(input logic [GCD_RES_W-1:0] a, input logic [GCD_RES_W-1:0] b,
                               input logic [31:0] base);
        qa.push_back(base);
        qa.push_back(base + TB_OFF);
        for (int k = 0; k < 21; k++) qw.push_back({k == 20, beat_of(a, k)});
        for (int k = 0; k < 21; k++) qw.push_back({k == 20, beat_of(b, k)});
    endtask

    task automatic issue_done(input logic [GCD_RES_W-1:0] a, input logic [GCD_RES_W-1:0] b,
                              input logic [31:0] base);
        @(posedge CLK); #1;
        RESULT_A = a; RESULT_B = b; BASE_ADDR = base; DONE = 1'b1;
        issue_cyc = cyc; aw_start = aw_hs_cnt; w_start = w_hs_cnt;
        push_expect(a, b, base);
        @(posedge CLK); #1;
        DONE = 1'b0;
        rand_res(RESULT_A);
        rand_res(RESULT_B);
        BASE_ADDR = $urandom;
        check_eq("busy_after_done", BUSY, 1);
        check_eq("err_after_done", ERR, 0);
    endtask

    task automatic wait_complete(input bit chk_lat);
        int n;
        n = 0;
        while (n < 5000) begin
            @(negedge CLK);
            if (COMPLETE) break;
            n++;
        end
        if (!COMPLETE) begin
            fail_now("complete_timeout");
        end else begin
            if (chk_lat) check_eq("latency", cyc - issue_cyc, 47);
            check_eq("busy_at_complete", BUSY, 0);
            check_eq("err_at_complete", ERR, exp_err);
            check_eq("aw_count", aw_hs_cnt - aw_start, 2);
            check_eq("w_count", w_hs_cnt - w_start, 42);
            check_eq("queues_drained", qa.size() + qw.size(), 0);
        end
    endtask

    task automatic wait_beats(input int nb);
        int n;
        n = 0;
        while (n < 2000 && (w_hs_cnt - w_start) < nb) begin
            @(posedge CLK); #2;
            n++;
        end
        if ((w_hs_cnt - w_start) < nb) fail_now("beat_wait_timeout");
    endtask

    always @(posedge CLK) cyc <= cyc + 1;

    // Slave side: handshake inputs change just after the active edge.
    always @(posedge CLK) begin
        #1;
        if (hs_pending) begin
            b_total++;
            hs_pending = 0;
        end
        AWREADY = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        WREADY  = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        BVALID  = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        BRESP   = (b_total == err_target) ? 2'b10 : 2'b00;
    end

    always @(negedge CLK) begin
        if (!RESETn) begin
            aw_outstanding = 0;
        end else begin
            if (AWVALID) begin
                if (qa.size() == 0) begin
                    fail_now("aw_unexpected");
                end else begin
                    check_eq("awaddr", AWADDR, qa[0]);
                    if (AWREADY) begin
                        void'(qa.pop_front());
                        aw_hs_cnt++;
                        aw_outstanding++;
                        check_eq("aw_const", {AWID, AWLEN, AWSIZE, AWBURST, AWLOCK, AWCACHE, AWPROT, WSTRB},
                                 {TB_ID, 8'd20, 3'b011, 2'b01, 1'b0, 4'b0011, 3'b000, 8'hFF});
                    end
                end
            end
            if (WVALID) begin
                check_eq("w_after_aw", aw_outstanding > 0, 1);
                if (qw.size() == 0) begin
                    fail_now("w_unexpected");
                end else begin
                    check_eq("wlast_wdata", {WLAST, WDATA}, qw[0]);
                    if (WREADY) begin
                        void'(qw.pop_front());
                        w_hs_cnt++;
                        if (WLAST) aw_outstanding--;
                    end
                end
            end
            if (BVALID && BREADY) hs_pending = 1;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [GCD_RES_W-1:0] a, b;
        logic [31:0] base;
        RESETn = 1'b0; DONE = 1'b0; BASE_ADDR = '0;
        RESULT_A = '0; RESULT_B = '0;
        AWREADY = 1'b0; WREADY = 1'b0; BVALID = 1'b0; BID = TB_ID; BRESP = 2'b00;
        repeat (3) @(posedge CLK);
        #1;
        check_eq("rst_valids", {AWVALID, WVALID, BREADY}, 0);
        check_eq("rst_flags", {BUSY, COMPLETE, ERR}, 0);
        check_eq("rst_awaddr", AWADDR, 0);
        check_eq("rst_wdata", WDATA, 0);
        #2 RESETn = 1'b1;

        // Basic write with an always-ready slave.
        a = '0; a[0] = 1'b1; b = '1;
        issue_done(a, b, 32'h8000_0000);
        wait_complete(1);
        @(negedge CLK);
        check_eq("complete_pulse", COMPLETE, 0);

        // Random backpressure.
        rnd_mode = 1'b1;
        for (int it = 0; it < 3; it++) begin
            rand_res(a); rand_res(b);
            base = $urandom & 32'hFFFF_FF00;
            issue_done(a, b, base);
            wait_complete(0);
            @(negedge CLK);
            check_eq("complete_pulse_rnd", COMPLETE, 0);
        end
        rnd_mode = 1'b0;

        // DONE while busy is ignored.
        rand_res(a); rand_res(b);
        issue_done(a, b, 32'h1234_5600);
        wait_beats(10);
        rand_res(RESULT_A); rand_res(RESULT_B);
        BASE_ADDR = 32'hDEAD_0000; DONE = 1'b1;
        @(posedge CLK); #1;
        DONE = 1'b0;
        wait_complete(0);

        // Reset mid-burst A, then a clean restart.
        rand_res(a); rand_res(b);
        issue_done(a, b, 32'h4000_0000);
        wait_beats(7);
        RESETn = 1'b0;
        #1;
        check_eq("abort_valids", {AWVALID, WVALID, BREADY}, 0);
        check_eq("abort_busy", BUSY, 0);
        check_eq("abort_wdata", WDATA, 0);
        qa.delete();
        qw.delete();
        repeat (2) @(posedge CLK);
        #3 RESETn = 1'b1;
        rand_res(a); rand_res(b);
        issue_done(a, b, 32'h4000_0200);
        wait_complete(1);

        // Error response on burst A.
        err_target = b_total;
`ifdef AXI_RESULT_PACKER_BRESP_CHECK_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        rand_res(a); rand_res(b);
        issue_done(a, b, 32'h0000_1000);
        wait_complete(1);
        err_target = -1;
        exp_err = 1'b0;

        // Back-to-back: DONE in the cycle after COMPLETE (also clears a set ERR).
        rand_res(a); rand_res(b);
        issue_done(a, b, 32'h0000_2000);
        wait_complete(1);
        rand_res(a); rand_res(b);
        issue_done(a, b, 32'hFFFF_FF00);
        wait_complete(1);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
